dem_tree_encoder: RTL

//  Parametrised tree-structured DEM encoder for the unit-element DAC.
//  - Input: quantizer code 0..2^N_LEVELS.
//  - Output: one enable bit per unit element (popcount == code).
//  - Built from N_LEVELS pipelined ranks of switching nodes; each node has

---
 rtl/dem_tree_encoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dem_tree_encoder.sv
// -----------------------------------------------------------------------------
// dem_tree_encoder
//   Tree-structured dynamic-element-matching encoder for a unit-element DAC.
//   A quantizer code 0..2^N_LEVELS is split recursively by N_LEVELS ranks of
//   switching nodes. Each rank is registered, so the latency is N_LEVELS
//   cycles. At every node an odd value is split unevenly. The direction of
//   the uneven split is chosen from PN dither and, when enabled, from a
//   first-order mismatch-shaping state.
//
//   Optional feature macro: DEM_SHAPING_EN
//     defined   : per-node shaping state q in {-1,0,+1}. An odd value
//                 splits against q, and PN breaks the tie when q == 0.
//     undefined : pure randomised DEM. An odd value splits in the
//                 direction given by PN alone.
//
// Ports
//   clk_i     clock
//   reset_i   synchronous active-high reset (clears pipeline and node states)
//   valid_i   x_in_i carries a sample this cycle
//   x_in_i    input code, unsigned; values above 2^N_LEVELS are clamped
//   pn_seq_i  PN dither, bit (2^l-1)+k drives node (l,k)
//   elem_o    unit-element enables (registered), popcount == clamped code
//   valid_o   elem_o carries a new sample this cycle
//   sat_o     sample on elem_o was clamped
// -----------------------------------------------------------------------------
module dem_tree_encoder #(
  parameter  int N_LEVELS  = 4,
  localparam int IN_W      = N_LEVELS + 1,
  localparam int NUM_ELEM  = 1 << N_LEVELS,
  localparam int NUM_NODES = NUM_ELEM - 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [IN_W-1:0]      x_in_i,
  input  logic [NUM_NODES-1:0] pn_seq_i,
  output logic [NUM_ELEM-1:0]  elem_o,
  output logic                 valid_o,
  output logic                 sat_o
);

  // Bit offset of rank l's outputs in the flattened rank bus. Rank l holds
  // 2^(l+1) values of N_LEVELS-l bits each.
  function automatic int rank_off(input int lvl);
    int acc;
    acc = 0;
    for (int j = 0; j < lvl; j++) begin
      acc = acc + (32'sd2 <<< j) * (N_LEVELS - j);
    end
    return acc;
  endfunction

  localparam int RANK_BITS = rank_off(N_LEVELS);

  logic [RANK_BITS-1:0] rank_s;
  logic [N_LEVELS-1:0]  rank_vld_s;
  logic [N_LEVELS-1:0]  rank_sat_s;
  logic [IN_W-1:0]      x_clamp_s;
  logic                 sat_s;

  // Clamp out-of-range codes to full scale and flag them.
  always_comb begin
    sat_s     = 1'b0;
    x_clamp_s = x_in_i;
    if (x_in_i > IN_W'(NUM_ELEM)) begin
      sat_s     = 1'b1;
      x_clamp_s = IN_W'(NUM_ELEM);
    end else begin
      sat_s     = 1'b0;
      x_clamp_s = x_in_i;
    end
  end

  for (genvar l = 0; l < N_LEVELS; l++) begin : g_lvl
    localparam int NN = 1 << l;          // nodes at this level
    localparam int VW = N_LEVELS - l + 1; // width of a node's input value
    localparam int OW = N_LEVELS - l;     // width of each child value

    logic [NN*VW-1:0]   v_in_s;
    logic               vld_in_s;
    logic               sat_in_s;
    logic [2*NN*OW-1:0] out_d;
    logic [2*NN*OW-1:0] out_q;
    logic               vld_q;
    logic               sat_q;

    if (l == 0) begin : g_src
      assign v_in_s   = x_clamp_s;
      assign vld_in_s = valid_i;
      assign sat_in_s = sat_s;
    end else begin : g_src
      assign v_in_s   = rank_s[rank_off(l-1) +: NN*VW];
      assign vld_in_s = rank_vld_s[l-1];
      assign sat_in_s = rank_sat_s[l-1];
    end

    for (genvar k = 0; k < NN; k++) begin : g_node
      logic [VW-1:0] v_s;
      logic [OW-1:0] half_s;
      logic          odd_s;
      logic          pn_s;
      logic          up_s;   // 1: s=+1 (extra unit to top child), 0: s=-1

      assign v_s    = v_in_s[k*VW +: VW];
      assign half_s = v_s[VW-1:1];
      assign odd_s  = v_s[0];
      assign pn_s   = pn_seq_i[NN-1+k];

`ifdef DEM_SHAPING_EN
      logic signed [1:0] q_q;
      logic signed [1:0] q_d;

      // Split against the stored imbalance; PN decides only when balanced.
      // Odd inputs toggle q between 0 and +/-1, so |q| never exceeds 1.
      always_comb begin
        up_s = pn_s;
        q_d  = q_q;
        if (q_q == 2'sd0) begin
          up_s = pn_s;
        end else begin
          up_s = q_q[1];
        end
        if (vld_in_s && odd_s) begin
          if (q_q == 2'sd0) begin
            q_d = up_s ? 2'sd1 : 2'sb11;
          end else begin
            q_d = 2'sd0;
          end
        end else begin
          q_d = q_q;
        end
      end

      // Node shaping state register.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          q_q <= 2'sd0;
        end else begin
          q_q <= q_d;
        end
      end
`else
      assign up_s = pn_s;
`endif

      // top = (v+s)>>1, bot = (v-s)>>1; s is nonzero only for odd v.
      assign out_d[(2*k)*OW   +: OW] = half_s + OW'(odd_s & up_s);
      assign out_d[(2*k+1)*OW +: OW] = half_s + OW'(odd_s & ~up_s);
    end

    // Rank register; data and saturation flag hold while the stage is idle.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        vld_q <= 1'b0;
        sat_q <= 1'b0;
        out_q <= '0;
      end else begin
        vld_q <= vld_in_s;
        if (vld_in_s) begin
          out_q <= out_d;
          sat_q <= sat_in_s;
        end
      end
    end

    assign rank_s[rank_off(l) +: 2*NN*OW] = out_q;
    assign rank_vld_s[l]                  = vld_q;
    assign rank_sat_s[l]                  = sat_q;
  end

  assign elem_o  = rank_s[rank_off(N_LEVELS-1) +: NUM_ELEM];
  assign valid_o = rank_vld_s[N_LEVELS-1];
  assign sat_o   = rank_sat_s[N_LEVELS-1];

endmodule
